// File: rtl/seq_mul_unit.sv
// -----------------------------------------------------------------------------
// seq_mul_unit
// Iterative shift-add multiplier feeding the CPU HI/LO path. A MULT (signed)
// or MULTU (unsigned) request starts a WIDTH-cycle shift-add loop on operand
// magnitudes, followed by one sign-fix cycle that stores the 2*WIDTH-bit
// product. An OUT request copies the stored product onto dataOut.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   op_valid  in   request strobe, sampled each rising edge
//   Signal    in   6-bit funct code of the request
//   dataA     in   multiplicand (sampled only on an accepted MULT/MULTU)
//   dataB     in   multiplier   (sampled only on an accepted MULT/MULTU)
//   busy      out  high while a multiply is in progress (CALC or FIX)
//   done      out  one-cycle pulse: product has been stored
//   reject    out  one-cycle pulse: MULT/MULTU/OUT dropped because busy
//   dataOut   out  registered product output, updated only by OUT or reset
// -----------------------------------------------------------------------------
module seq_mul_unit #(
    parameter int         WIDTH       = 32,
    parameter logic [5:0] FUNCT_MULT  = 6'd24,
    parameter logic [5:0] FUNCT_MULTU = 6'd25,
    parameter logic [5:0] FUNCT_OUT   = 6'd63
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_valid,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic                 reject,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int                CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [2*WIDTH:0]     acc_r, acc_s;
    logic [WIDTH-1:0]     a_mag_r, a_mag_s;
    logic [WIDTH-1:0]     b_mag_r, b_mag_s;
    logic                 neg_r, neg_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [2*WIDTH-1:0]   prod_r, prod_s;
    logic [2*WIDTH-1:0]   dout_s;
    logic                 busy_s, done_s, reject_s;
    logic [WIDTH:0]       upper_s;
    logic                 is_mul_s, is_out_s;

    // Two's-complement magnitude as an unsigned WIDTH-bit value; the most
    // negative input maps onto 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Next-state, datapath and output decode for the IDLE/CALC/FIX sequencer.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        a_mag_s  = a_mag_r;
        b_mag_s  = b_mag_r;
        neg_s    = neg_r;
        cnt_s    = cnt_r;
        prod_s   = prod_r;
        dout_s   = dataOut;
        done_s   = 1'b0;
        reject_s = 1'b0;
        // Upper accumulator half plus multiplicand; the top accumulator bit
        // is always zero here, so the sum never carries out of WIDTH+1 bits.
        upper_s  = acc_r[2*WIDTH:WIDTH] + {1'b0, a_mag_r};
        is_mul_s = op_valid && ((Signal == FUNCT_MULT) || (Signal == FUNCT_MULTU));
        is_out_s = op_valid && (Signal == FUNCT_OUT);

        case (state_r)
            IDLE: begin
                if (is_mul_s) begin
                    if (Signal == FUNCT_MULT) begin
                        a_mag_s = abs_mag(dataA);
                        b_mag_s = abs_mag(dataB);
                        neg_s   = dataA[WIDTH-1] ^ dataB[WIDTH-1];
                    end else begin
                        a_mag_s = dataA;
                        b_mag_s = dataB;
                        neg_s   = 1'b0;
                    end
                    acc_s   = {(2*WIDTH+1){1'b0}};
                    cnt_s   = CNT_LOAD;
                    state_s = CALC;
                end else if (is_out_s) begin
                    dout_s = prod_r;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                reject_s = is_mul_s || is_out_s;
                if (b_mag_r[0]) begin
                    acc_s = {1'b0, upper_s, acc_r[WIDTH-1:1]};
                end else begin
                    acc_s = {1'b0, acc_r[2*WIDTH:1]};
                end
                b_mag_s = {1'b0, b_mag_r[WIDTH-1:1]};
                cnt_s   = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                reject_s = is_mul_s || is_out_s;
                if (neg_r) begin
                    prod_s = ~acc_r[2*WIDTH-1:0] + ONE_2W;
                end else begin
                    prod_s = acc_r[2*WIDTH-1:0];
                end
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            acc_r   <= {(2*WIDTH+1){1'b0}};
            a_mag_r <= {WIDTH{1'b0}};
            b_mag_r <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            prod_r  <= {(2*WIDTH){1'b0}};
            dataOut <= {(2*WIDTH){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            reject  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
            neg_r   <= neg_s;
            cnt_r   <= cnt_s;
            prod_r  <= prod_s;
            dataOut <= dout_s;
            busy    <= busy_s;
            done    <= done_s;
            reject  <= reject_s;
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_unit
// Scoreboard bench for seq_mul_unit. Two instances (WIDTH=32 and WIDTH=8)
// share one driver; a selector picks which one is active. The driver works out
// expected done/reject/OUT events from a cycle-level reference model and
// pushes them into queues; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_seq_mul_unit;

    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_OUT   = 6'd63;
    localparam logic [5:0] F_OTHER = 6'd10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_s = 1'b0;
    logic        sel = 1'b0;
    logic [5:0]  sig_s = 6'd0;
    logic [31:0] a_s = 32'd0;
    logic [31:0] b_s = 32'd0;

    logic        op32_s, op8_s;
    logic        busy32_s, done32_s, reject32_s;
    logic        busy8_s, done8_s, reject8_s;
    logic [63:0] dout32_s;
    logic [15:0] dout8_s;
    logic [7:0]  a8_s, b8_s;

    assign op32_s = op_s & ~sel;
    assign op8_s  = op_s & sel;
    assign a8_s   = a_s[7:0];
    assign b8_s   = b_s[7:0];

    seq_mul_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .op_valid(op32_s), .Signal(sig_s),
        .dataA(a_s), .dataB(b_s), .busy(busy32_s), .done(done32_s),
        .reject(reject32_s), .dataOut(dout32_s)
    );

    seq_mul_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .op_valid(op8_s), .Signal(sig_s),
        .dataA(a8_s), .dataB(b8_s), .busy(busy8_s), .done(done8_s),
        .reject(reject8_s), .dataOut(dout8_s)
    );

    always #5 clk = ~clk;

    // Edge counter: value at a falling edge is the index of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        longint unsigned val;
    } out_t;

    int   done_q[$];
    int   rej_q[$];
    out_t out_q[$];

    // Reference model state, written by the driver.
    int              cur_w = 32;
    bit              have_acc = 1'b0;
    int              acc_edge = 0;
    longint unsigned model_prod = 64'd0;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, width %0d)", name, act, exp, cyc, cur_w);
        end
    endtask

    // Exact product by plain integer arithmetic, reduced to 2*w bits.
    function automatic longint unsigned ref_mul(input bit sgn, input longint unsigned a,
                                                input longint unsigned b, input int w);
        longint          sa, sb;
        longint unsigned mw, mask;
        mw = (64'd1 << w) - 64'd1;
        sa = longint'(a & mw);
        sb = longint'(b & mw);
        if (sgn && a[w-1]) sa = sa - longint'(64'd1 << w);
        if (sgn && b[w-1]) sb = sb - longint'(64'd1 << w);
        if (w >= 32) mask = 64'hFFFF_FFFF_FFFF_FFFF;
        else         mask = (64'd1 << (2 * w)) - 64'd1;
        return longint'(sa * sb) & mask;
    endfunction

    // Issue one request for one cycle and record what the unit must do with it.
    task automatic issue(input logic [5:0] fn, input longint unsigned a, input longint unsigned b);
        int  f;
        bit  busy_m;
        f      = cyc + 1;
        busy_m = have_acc && (f <= acc_edge + cur_w + 1);
        op_s   = 1'b1;
        sig_s  = fn;
        a_s    = a[31:0];
        b_s    = b[31:0];
        if (fn == F_MULT || fn == F_MULTU || fn == F_OUT) begin
            if (busy_m) begin
                rej_q.push_back(f);
            end else if (fn == F_OUT) begin
                out_q.push_back('{f, model_prod});
            end else begin
                model_prod = ref_mul(fn == F_MULT, a, b, cur_w);
                acc_edge   = f;
                have_acc   = 1'b1;
                done_q.push_back(f + cur_w + 1);
            end
        end
        @(negedge clk);
        op_s = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Return in the cycle the last multiply reports done (first free cycle).
    task automatic wait_idle();
        while (have_acc && (cyc + 1 <= acc_edge + cur_w + 1)) @(negedge clk);
    endtask

    // Asynchronous reset between edges; optionally switch active instance.
    task automatic do_reset(input logic new_sel);
        #2;
        reset = 1'b0;
        done_q.delete();
        rej_q.delete();
        out_q.delete();
        out_q.push_back('{cyc + 1, 64'd0});
        have_acc   = 1'b0;
        model_prod = 64'd0;
        #1;
        check("busy_async_clear", sel ? busy8_s : busy32_s, 64'd0);
        sel   = new_sel;
        cur_w = new_sel ? 8 : 32;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic longint unsigned rnd_op();
        int k;
        k = $urandom_range(0, 5);
        if (k == 0) return 64'h8000_0000;
        if (k == 1) return 64'hFFFF_FFFF;
        if (k == 2) return 64'd1;
        return longint'($urandom);
    endfunction

    // Monitor: compare DUT outputs against the expectation queues.
    logic            exp_done_m, exp_rej_m, exp_busy_m;
    logic            done_m, rej_m, busy_m;
    longint unsigned dout_m;
    longint unsigned dout_exp = 64'd0;
    int              tmp_i;
    out_t            tmp_o;

    always @(negedge clk) begin
        done_m = sel ? done8_s : done32_s;
        rej_m  = sel ? reject8_s : reject32_s;
        busy_m = sel ? busy8_s : busy32_s;
        dout_m = sel ? {48'd0, dout8_s} : dout32_s;

        exp_done_m = 1'b0;
        if (done_q.size() > 0) begin
            if (done_q[0] == cyc) begin
                exp_done_m = 1'b1;
                tmp_i = done_q.pop_front();
            end
        end
        if (done_m || exp_done_m) check("done_pulse", done_m, exp_done_m);

        exp_rej_m = 1'b0;
        if (rej_q.size() > 0) begin
            if (rej_q[0] == cyc) begin
                exp_rej_m = 1'b1;
                tmp_i = rej_q.pop_front();
            end
        end
        if (rej_m || exp_rej_m) check("reject_pulse", rej_m, exp_rej_m);

        if (out_q.size() > 0) begin
            if (out_q[0].cyc == cyc) begin
                tmp_o    = out_q.pop_front();
                dout_exp = tmp_o.val;
            end
        end
        check("dataOut", dout_m, dout_exp);

        exp_busy_m = have_acc && (cyc >= acc_edge) && (cyc <= acc_edge + cur_w);
        check("busy", busy_m, exp_busy_m);
    end

    initial begin
        int k;
        logic [5:0] fn;

        // Reset held low for two cycles.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic unsigned multiply, then read back.
        issue(F_MULTU, 64'd10, 64'd20);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        idle(2);

        // Signed and unsigned views of the same operands.
        issue(F_MULT, 64'hFFFF_FFFD, 64'd7);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_MULTU, 64'hFFFF_FFFD, 64'd7);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);

        // Corner operands.
        issue(F_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_MULT, 64'h8000_0000, 64'h8000_0000);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_MULT, 64'h8000_0000, 64'd1);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);

        // Requests while busy: rejected multiply, rejected OUT, ignored funct.
        issue(F_MULTU, 64'd5, 64'd15);
        idle(9);
        issue(F_MULTU, 64'd2, 64'd2);
        idle(3);
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_OTHER, 64'd9, 64'd9);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_OTHER, 64'd1, 64'd1);

        // Back-to-back: new multiply and OUT each in a done cycle.
        issue(F_MULTU, 64'd5, 64'd15);
        wait_idle();
        issue(F_MULTU, 64'd3, 64'd4);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        idle(2);

        // Randomized mix of requests and gaps.
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4)      fn = F_MULTU;
            else if (k < 7) fn = F_MULT;
            else if (k < 9) fn = F_OUT;
            else            fn = F_OTHER;
            issue(fn, rnd_op(), rnd_op());
            if ($urandom_range(0, 2) == 0) wait_idle();
            else idle($urandom_range(0, 12));
        end
        wait_idle();
        issue(F_MULT, 64'hFFFF_FFF0, 64'd3);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);

        // Reset in the middle of a multiply: no done, product reads zero.
        issue(F_MULTU, 64'd123, 64'd456);
        idle(9);
        do_reset(1'b0);
        issue(F_OUT, 64'd0, 64'd0);
        idle(3);

        // Switch to the WIDTH=8 instance.
        do_reset(1'b1);
        issue(F_MULT, 64'h80, 64'h7F);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        issue(F_MULTU, 64'hFF, 64'hFF);
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 3);
            fn = (k == 0) ? F_MULTU : ((k == 1) ? F_MULT : F_OUT);
            issue(fn, longint'($urandom_range(0, 255)), longint'($urandom_range(0, 255)));
            idle($urandom_range(0, 10));
        end
        wait_idle();
        issue(F_OUT, 64'd0, 64'd0);

        // Let every outstanding expectation be consumed, within a bound.
        for (int i = 0; i < 200 && (done_q.size() + rej_q.size() + out_q.size()) != 0; i++) begin
            @(negedge clk);
        end
        check("queues_drained", longint'(done_q.size() + rej_q.size() + out_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Parameterised, iterative shift-add multiplier for the pipelined CPU's HI/LO path.
- Successor to the fixed 32-bit MULTU-only unit:
  - adds signed MULT;
  - adds an explicit request/busy/done/reject handshake;
  - operand width is generic.
- Decoded by ALU funct code (6-bit Signal). The execute stage issues an operation, then reads the result with the OUT funct.

Parameters:
- WIDTH, 32: operand width. Product is 2*WIDTH. Legal range 4..64.
- FUNCT_MULT, 6'd24: funct code for a signed multiply.
- FUNCT_MULTU, 6'd25: funct code for an unsigned multiply.
- FUNCT_OUT, 6'd63: funct code that copies the stored product to dataOut.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op_valid  in  1  request strobe, sampled each rising edge.
- Signal  in  6  funct code of the request.
- dataA  in  WIDTH  multiplicand, sampled only on an accepted MULT/MULTU.
- dataB  in  WIDTH  multiplier, sampled only on an accepted MULT/MULTU.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse: product is stored.
- reject  out  1  one-cycle pulse: request dropped because the unit was busy.
- dataOut  out  2*WIDTH  registered product output.

Behaviour:
- Reset (reset==0, async):
  - state=IDLE;
  - busy, done, reject = 0;
  - dataOut = 0, stored product = 0, counter = 0.
  - A reset mid-operation aborts the multiply. No done is issued, and the stored product reads 0.
- States: IDLE, CALC, FIX. busy=1 exactly in CALC and FIX. done and reject are registered and default to 0 each cycle.
- IDLE, op_valid=1, Signal=FUNCT_MULTU:
  - latch a_mag=dataA, b_mag=dataB, neg=0;
  - clear the accumulator; counter=WIDTH; go to CALC.
- IDLE, op_valid=1, Signal=FUNCT_MULT:
  - latch a_mag=|dataA| and b_mag=|dataB|, both as WIDTH-bit unsigned values (so -2^(WIDTH-1) gives 2^(WIDTH-1));
  - neg = dataA[MSB] ^ dataB[MSB];
  - then proceed as for MULTU.
- IDLE, op_valid=1, Signal=FUNCT_OUT: dataOut <= stored product on that edge. State stays IDLE.
- op_valid=1 with any other funct code: ignored in every state. No reject, no state change.
- CALC, one multiplier bit per cycle, LSB first:
  - if b_mag[0]=1, add a_mag into the upper half of the 2*WIDTH+1 accumulator;
  - shift the accumulator right by 1;
  - shift b_mag right by 1;
  - decrement counter;
  - on counter reaching 1→0, go to FIX.
  - CALC lasts exactly WIDTH cycles.
- FIX:
  - stored product <= neg ? two's-complement negation of the accumulator : the accumulator, truncated to 2*WIDTH bits;
  - done <= 1; state <= IDLE.
- Latency: accept edge = edge 0 → done=1 after edge WIDTH+1, visible for one cycle. Total occupancy is WIDTH+1 cycles.
- Back-to-back: the done cycle is already IDLE, so a MULT/MULTU/OUT request in that cycle is accepted. An OUT in the done cycle returns the new product.
- Request while busy:
  - any op_valid with MULT, MULTU or OUT while busy=1 → reject <= 1 for one cycle;
  - operands are not latched; the in-flight operation continues unaffected;
  - dataOut holds.
- dataOut changes only on an accepted OUT or on reset. A MULT/MULTU does not disturb dataOut.
- Arithmetic: the result is exact for all inputs. There is no overflow, because 2*WIDTH bits hold any product.

Test Plan (WIDTH=32 unless stated):
- Reset low for 2 cycles, then MULTU dataA=10, dataB=20 → busy=1 for 33 cycles, done pulse 33 cycles after accept. Then OUT → dataOut=200 on the next edge.
- MULT dataA=-3 (0xFFFFFFFD), dataB=7 → OUT gives dataOut=0xFFFFFFFFFFFFFFEB. MULTU with the same operands → 0x00000006FFFFFFEB.
- Corner values:
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001;
  - MULT 0x80000000×0x80000000 → 0x4000000000000000;
  - MULT 0x80000000×1 → 0xFFFFFFFF80000000.
- Busy rejection:
  - issue MULTU 5×15, then MULTU 2×2 ten cycles later → reject pulse, busy unchanged;
  - final OUT=75;
  - an OUT issued mid-operation → reject, and dataOut keeps its old value.
- Back-to-back and reset:
  - in the done cycle of 5×15, issue MULTU 3×4 → accepted, and OUT returns 12 after the second done;
  - in a separate run, assert reset at CALC cycle 10 → busy=0 immediately, no done, and a following OUT returns 0.
- WIDTH=8 instance:
  - MULT 0x80×0x7F → 0xC080;
  - MULTU 0xFF×0xFF → 0xFE01;
  - done arrives 9 cycles after accept.
